// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI register-bank peripheral.
// Frame layout helper plus FSM encoding; no logic, no latency, no backpressure.
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } spi_state_e;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    function automatic int frame_w(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Resynchronises async sclk/ncs/copi into clk and derives sclk rise/fall pulses.
// Latency: SYNC_STAGES clks to the synced level, edge pulse in that same cycle; no backpressure.
module spi_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sclk,
    input  logic ncs,
    input  logic copi,
    output logic ncs_s,
    output logic copi_s,
    output logic sclk_rise,
    output logic sclk_fall
);

    logic [SYNC_STAGES-1:0] sclk_q;
    logic [SYNC_STAGES-1:0] ncs_q;
    logic [SYNC_STAGES-1:0] copi_q;
    logic                   sclk_prev_q;

    // ncs chain resets high so the bus looks deselected while coming out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q      <= '0;
            ncs_q       <= '1;
            copi_q      <= '0;
            sclk_prev_q <= 1'b0;
        end else begin
            sclk_q      <= {sclk_q[SYNC_STAGES-2:0], sclk};
            ncs_q       <= {ncs_q[SYNC_STAGES-2:0], ncs};
            copi_q      <= {copi_q[SYNC_STAGES-2:0], copi};
            sclk_prev_q <= sclk_q[SYNC_STAGES-1];
        end
    end

    assign ncs_s     = ncs_q[SYNC_STAGES-1];
    assign copi_s    = copi_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_q[SYNC_STAGES-1] & ~sclk_prev_q;
    assign sclk_fall = ~sclk_q[SYNC_STAGES-1] & sclk_prev_q;

endmodule

// File: rtl/spi_regbank_peripheral.sv
// SPI mode-0 slave exposing NUM_REGS config registers with readback, write strobes and error pulse.
// Latency: commit one clk after the last synced sclk rise; no backpressure (controller-paced SPI).
module spi_regbank_peripheral
    import spi_pkg::*;
#(
    parameter int NUM_REGS    = 5,
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 7,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sclk,
    input  logic                       ncs,
    input  logic                       copi,
    output logic                       cipo,
    output logic                       cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0] regs_flat,
    output logic [NUM_REGS-1:0]        wr_strobe,
    output logic                       err_pulse
);

    localparam int                FRAME_W = frame_w(ADDR_W, DATA_W);
    localparam int                CNT_W   = $clog2(FRAME_W + 1);
    localparam logic [ADDR_W:0]   ADDR_LIM = (ADDR_W + 1)'(NUM_REGS);

    logic ncs_s, copi_s, sclk_rise, sclk_fall;

    spi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .sclk      (sclk),
        .ncs       (ncs),
        .copi      (copi),
        .ncs_s     (ncs_s),
        .copi_s    (copi_s),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall)
    );

    spi_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [FRAME_W-1:0]    shift_q, shift_d;
    logic [DATA_W-1:0]     shadow_q, shadow_d;
    logic                  rd_q, rd_d;
    logic                  cipo_q, cipo_d;
    logic                  err_q, err_d;
    logic [NUM_REGS-1:0]   wr_strobe_q, wr_strobe_d;
    logic [DATA_W-1:0]     regs_q [NUM_REGS];

    logic [FRAME_W-1:0]    shift_in;
    logic [ADDR_W-1:0]     cmd_addr, frm_addr;
    logic                  cmd_rw, frm_rw;
    logic [DATA_W-1:0]     frm_data;
    logic [DATA_W-1:0]     rd_val;
    logic                  wr_en;
    logic [CNT_W-1:0]      cnt_inc;

    // The word as it will look once the bit being sampled this cycle is shifted in
    assign shift_in = {shift_q[FRAME_W-2:0], copi_s};
    assign cmd_rw   = shift_in[ADDR_W];
    assign cmd_addr = shift_in[ADDR_W-1:0];
    assign frm_rw   = shift_in[FRAME_W-1];
    assign frm_addr = shift_in[FRAME_W-2 -: ADDR_W];
    assign frm_data = shift_in[DATA_W-1:0];
    assign cnt_inc  = (cnt_q == CNT_W'(FRAME_W)) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        rd_val = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (cmd_addr == ADDR_W'(r)) rd_val = regs_q[r];
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        shadow_d = shadow_q;
        rd_d     = rd_q;
        cipo_d   = (state_q == ST_DATA && rd_q) ? cipo_q : 1'b0;
        err_d    = 1'b0;
        wr_en    = 1'b0;
        if (ncs_s) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            shift_d  = '0;
            shadow_d = '0;
            rd_d     = 1'b0;
            cipo_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_CMD;
                    rd_d    = 1'b0;
                end
                ST_CMD: begin
                    if (sclk_rise) begin
                        shift_d = shift_in;
                        cnt_d   = cnt_inc;
                        if (cnt_q == CNT_W'(ADDR_W)) begin
                            state_d = ST_DATA;
                            rd_d    = (cmd_rw == RW_READ);
                            if (cmd_rw == RW_READ) begin
                                if ({1'b0, cmd_addr} < ADDR_LIM) begin
                                    shadow_d = rd_val;
                                end else begin
                                    shadow_d = '0;
                                    err_d    = 1'b1;
                                end
                            end
                        end
                    end
                end
                ST_DATA: begin
                    if (rd_q && sclk_fall) begin
                        cipo_d   = shadow_q[DATA_W-1];
                        shadow_d = {shadow_q[DATA_W-2:0], 1'b0};
                    end
                    if (sclk_rise) begin
                        shift_d = shift_in;
                        cnt_d   = cnt_inc;
                        if (cnt_q == CNT_W'(FRAME_W - 1)) begin
                            state_d = ST_DONE;
                            if (frm_rw == RW_WRITE) begin
                                if ({1'b0, frm_addr} < ADDR_LIM) wr_en = 1'b1;
                                else                              err_d = 1'b1;
                            end
                        end
                    end
                end
                default: ; // DONE: surplus sclk rises are ignored until ncs rises
            endcase
        end
    end

    always_comb begin
        wr_strobe_d = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            wr_strobe_d[r] = wr_en && (frm_addr == ADDR_W'(r));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            shadow_q    <= '0;
            rd_q        <= 1'b0;
            cipo_q      <= 1'b0;
            err_q       <= 1'b0;
            wr_strobe_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            shadow_q    <= shadow_d;
            rd_q        <= rd_d;
            cipo_q      <= cipo_d;
            err_q       <= err_d;
            wr_strobe_q <= wr_strobe_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (wr_strobe_d[r]) regs_q[r] <= frm_data;
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[g*DATA_W +: DATA_W] = regs_q[g];
    end

    assign cipo      = cipo_q;
    assign cipo_oe   = ~ncs_s;
    assign wr_strobe = wr_strobe_q;
    assign err_pulse = err_q;

endmodule

// File: tb/tb_spi_regbank_peripheral.sv
// Directed bench for spi_regbank_peripheral: scoreboarded write strobes, readback and error pulses.
module tb_spi_regbank_peripheral;

    localparam int NR = 5;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sclk = 1'b0;
    logic ncs = 1'b1;
    logic copi = 1'b0;
    logic cipo, cipo_oe, err_pulse;
    logic [NR*DW-1:0] regs_flat;
    logic [NR-1:0]    wr_strobe;

    int checks = 0;
    int failures = 0;
    int err_cnt = 0;
    int exp_err = 0;

    logic [NR+NR*DW-1:0] obs_q[$];
    logic [NR+NR*DW-1:0] exp_q[$];
    logic [DW-1:0]       rd_exp_q[$];
    logic [NR*DW-1:0]    model = '0;

    always #5 clk = ~clk;

    spi_regbank_peripheral dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sclk      (sclk),
        .ncs       (ncs),
        .copi      (copi),
        .cipo      (cipo),
        .cipo_oe   (cipo_oe),
        .regs_flat (regs_flat),
        .wr_strobe (wr_strobe),
        .err_pulse (err_pulse)
    );

    // Every cycle a strobe is high is one observed commit; a stretched strobe shows up as extra entries
    always @(negedge clk) begin
        if (wr_strobe !== '0) obs_q.push_back({wr_strobe, regs_flat});
        if (err_pulse === 1'b1) err_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic half_bit();
        repeat (5) @(negedge clk);
    endtask

    task automatic frame(input logic [15:0] f, input int nbits, input bit release_cs,
                         output logic [DW-1:0] rd);
        rd = '0;
        ncs = 1'b0;
        half_bit();
        for (int i = 0; i < nbits; i++) begin
            copi = (i < 16) ? f[15-i] : 1'b1;
            half_bit();
            if (i >= 8 && i < 16) rd = {rd[DW-2:0], cipo};
            sclk = 1'b1;
            half_bit();
            sclk = 1'b0;
        end
        half_bit();
        if (release_cs) begin
            ncs  = 1'b1;
            copi = 1'b0;
            repeat (10) @(negedge clk);
        end
    endtask

    task automatic expect_write(input int addr, input logic [DW-1:0] data);
        logic [NR-1:0] oh;
        if (addr < NR) begin
            oh = '0;
            oh[addr] = 1'b1;
            model[addr*DW +: DW] = data;
            exp_q.push_back({oh, model});
        end else begin
            exp_err++;
        end
    endtask

    task automatic drain(input string tag);
        logic [NR+NR*DW-1:0] o, e;
        chk({tag, "_ncommit"}, 64'(obs_q.size()), 64'(exp_q.size()));
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            chk({tag, "_commit"}, 64'(o), 64'(e));
        end
        obs_q.delete();
        exp_q.delete();
        chk({tag, "_regs"}, 64'(regs_flat), 64'(model));
        chk({tag, "_errs"}, 64'(err_cnt), 64'(exp_err));
    endtask

    task automatic check_read(input string tag, input logic [DW-1:0] rd);
        logic [DW-1:0] e;
        if (rd_exp_q.size() == 0) begin
            chk({tag, "_rdq_empty"}, 64'(1), 64'(0));
        end else begin
            e = rd_exp_q.pop_front();
            chk({tag, "_rdata"}, 64'(rd), 64'(e));
        end
    endtask

    initial begin
        logic [DW-1:0] rd;

        repeat (3) @(negedge clk);
        chk("rst_regs", 64'(regs_flat), 64'(0));
        chk("rst_cipo", 64'(cipo), 64'(0));
        chk("rst_oe", 64'(cipo_oe), 64'(0));
        chk("rst_strobe", 64'(wr_strobe), 64'(0));
        chk("rst_err", 64'(err_pulse), 64'(0));
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        expect_write(0, 8'hA5);
        frame(16'h80A5, 16, 1'b1, rd);
        expect_write(4, 8'h3C);
        frame(16'h843C, 16, 1'b1, rd);
        drain("wr0_wr4");
        chk("oe_idle", 64'(cipo_oe), 64'(0));

        rd_exp_q.push_back(8'h3C);
        frame(16'h0400, 16, 1'b1, rd);
        check_read("rd4", rd);
        chk("cipo_idle", 64'(cipo), 64'(0));
        drain("rd4");

        expect_write(5, 8'hFF);
        frame(16'h85FF, 16, 1'b1, rd);
        drain("wr_bad");
        rd_exp_q.push_back(8'h00);
        exp_err++;
        frame(16'h0700, 16, 1'b1, rd);
        check_read("rd_bad", rd);
        drain("rd_bad");

        frame(16'h81F0, 12, 1'b1, rd);
        drain("short");

        expect_write(2, 8'h55);
        frame(16'h8255, 21, 1'b1, rd);
        drain("long");

        frame(16'h8377, 10, 1'b0, rd);
        chk("oe_active", 64'(cipo_oe), 64'(1));
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        model = '0;
        chk("midrst_regs", 64'(regs_flat), 64'(0));
        chk("midrst_oe", 64'(cipo_oe), 64'(0));
        ncs = 1'b1;
        copi = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        drain("midrst");

        expect_write(3, 8'h77);
        frame(16'h8377, 16, 1'b1, rd);
        drain("wr3");
        rd_exp_q.push_back(8'h77);
        frame(16'h0300, 16, 1'b1, rd);
        check_read("rd3", rd);
        rd_exp_q.push_back(8'h00);
        frame(16'h0000, 16, 1'b1, rd);
        check_read("rd0_after_rst", rd);
        drain("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
